lstm_seq_ctrl: RTL and testbench

Sequencer for the `lstm` cell. It accepts a stream of input samples, drives each one into the cell's `x_in/x_valid/x_ready` port, and waits for `y_valid`. It then latches `y_out`/`C_out` as recurrent state for the cell's `h_in`/`C_in` and forwards the result downstream. It closes the recurrent loop around `lstm`, handles sequence boundaries, and detects a stalled cell.

---
 rtl/lstm_pkg.sv | 6 +
 rtl/lstm_seq_ctrl.sv | 104 ++++++++++
 tb/tb_lstm_seq_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/lstm_pkg.sv
// lstm_pkg: shared types and defaults for the lstm cell and its sequencer.
package lstm_pkg;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} lstm_seq_state_t;
  typedef logic signed [DATA_W-1:0] sample_t;
endpackage

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: one-sample-at-a-time sequencer closing the h/C recurrent loop around lstm.
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int WIDTH   = DATA_W,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] s_x,
  input  logic                    s_first,
  input  logic                    s_last,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic signed [WIDTH-1:0] x_in,
  output logic                    x_valid,
  input  logic                    x_ready,
  output logic signed [WIDTH-1:0] h_in,
  output logic signed [WIDTH-1:0] C_in,
  input  logic signed [WIDTH-1:0] y_out,
  input  logic signed [WIDTH-1:0] C_out,
  input  logic                    y_valid,
  output logic signed [WIDTH-1:0] m_y,
  output logic                    m_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [CNT_W-1:0]        step,
  output logic                    err_timeout
);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  lstm_seq_state_t r_state;
  logic [TO_W-1:0] r_cnt;
  logic            r_last;
  logic            w_timeout;
  assign w_timeout = r_cnt == TO_W'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      s_ready     <= 1'b0;
      x_in        <= '0;
      x_valid     <= 1'b0;
      h_in        <= '0;
      C_in        <= '0;
      m_y         <= '0;
      m_last      <= 1'b0;
      m_valid     <= 1'b0;
      step        <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            r_state <= ISSUE;
            s_ready <= 1'b0;
            x_valid <= 1'b1;
            x_in    <= s_x;
            r_last  <= s_last;
            if (s_first) begin
              h_in <= '0;
              C_in <= '0;
              step <= '0;
            end
          end
        end
        ISSUE: if (x_ready) begin
          r_state <= WAIT;
          x_valid <= 1'b0;
          r_cnt   <= '0;
        end
        WAIT: begin
          if (y_valid) begin
            r_state <= EMIT;
            h_in    <= y_out;
            C_in    <= C_out;
            m_y     <= y_out;
            m_last  <= r_last;
            m_valid <= 1'b1;
          end else if (w_timeout) begin
            // stalled cell: drop the result and restart the sequence from zero state
            r_state     <= IDLE;
            err_timeout <= 1'b1;
            h_in        <= '0;
            C_in        <= '0;
            step        <= '0;
            s_ready     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        EMIT: if (m_ready) begin
          r_state <= IDLE;
          m_valid <= 1'b0;
          s_ready <= 1'b1;
          step    <= m_last ? '0 : (&step ? step : step + 1'b1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb_lstm_seq_ctrl: vector table, random sequences vs a sample-level model, and stall/reset corner cases.
module tb_lstm_seq_ctrl;
  logic        clk = 0, rst = 1;
  logic [15:0] s_x = 0, x_in, h_in, C_in, y_out = 0, C_out = 0, m_y;
  logic        s_first = 0, s_last = 0, s_valid = 0, s_ready;
  logic        x_valid, x_ready = 0, y_valid = 0;
  logic        m_last, m_valid, m_ready = 0, err_timeout;
  logic [2:0]  step;
  int          checks = 0, errors = 0;
  logic [15:0] mh = 0, mc = 0, my = 0;
  logic [2:0]  mstep = 0;

  typedef struct {
    logic [15:0] x;
    logic        f, l;
    int          lat, xs, ms;
    logic [15:0] y, c, eh, ec;
    logic [2:0]  s0, s1;
  } vec_t;
  vec_t vecs[6];

  lstm_seq_ctrl #(.WIDTH(16), .TIMEOUT(16), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .s_x(s_x), .s_first(s_first), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready), .x_in(x_in), .x_valid(x_valid),
    .x_ready(x_ready), .h_in(h_in), .C_in(C_in), .y_out(y_out), .C_out(C_out),
    .y_valid(y_valid), .m_y(m_y), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .step(step), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_x_valid", x_valid, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_x_in", x_in, 0);
    chk("rst_h_in", h_in, 0);
    chk("rst_C_in", C_in, 0);
    chk("rst_m_y", m_y, 0);
    chk("rst_step", step, 0);
  endtask

  task automatic accept(input logic [15:0] x, input logic f, input logic l);
    int n = 0;
    while (!s_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready_idle", s_ready, 1);
    s_x = x; s_first = f; s_last = l; s_valid = 1;
    @(negedge clk);
    s_valid = 0; s_x = 16'($urandom); s_first = 1'($urandom); s_last = 1'($urandom);
    chk("x_valid_issue", x_valid, 1);
    chk("x_in", x_in, x);
    chk("s_ready_busy", s_ready, 0);
  endtask

  task automatic run_sample(input logic [15:0] x, input logic f, input logic l,
                            input int lat, input int xs, input int ms,
                            input logic [15:0] y, input logic [15:0] c,
                            input logic [15:0] eh, input logic [15:0] ec,
                            input logic [2:0] s0, input logic [2:0] s1);
    accept(x, f, l);
    chk("h_in_issue", h_in, eh);
    chk("C_in_issue", C_in, ec);
    chk("step_issue", step, s0);
    for (int k = 0; k < xs; k++) begin
      @(negedge clk);
      chk("x_valid_hold", x_valid, 1);
      chk("x_in_hold", x_in, x);
    end
    x_ready = 1;
    @(negedge clk);
    x_ready = 0;
    chk("x_valid_drop", x_valid, 0);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      chk("m_valid_wait", m_valid, 0);
      chk("h_in_wait", h_in, eh);
    end
    y_out = y; C_out = c; y_valid = 1;
    @(negedge clk);
    y_valid = 0; y_out = 16'($urandom); C_out = 16'($urandom);
    chk("m_valid_emit", m_valid, 1);
    chk("m_y", m_y, y);
    chk("m_last", m_last, l);
    chk("h_in_latch", h_in, y);
    chk("C_in_latch", C_in, c);
    for (int k = 0; k < ms; k++) begin
      y_valid = (k == 0);
      @(negedge clk);
      y_valid = 0;
      chk("m_valid_hold", m_valid, 1);
      chk("m_y_hold", m_y, y);
      chk("h_in_hold", h_in, y);
      chk("C_in_hold", C_in, c);
    end
    m_ready = 1;
    @(negedge clk);
    m_ready = 0;
    chk("m_valid_drop", m_valid, 0);
    chk("step_after", step, s1);
    chk("s_ready_back", s_ready, 1);
  endtask

  task automatic model_sample(input logic f, input logic l);
    logic [15:0] y, c;
    logic [2:0]  ns;
    y = 16'($urandom); c = 16'($urandom);
    if (f) begin mh = 0; mc = 0; mstep = 0; end
    ns = l ? 3'd0 : (mstep == 3'd7 ? 3'd7 : mstep + 3'd1);
    run_sample(16'($urandom), f, l, $urandom_range(1, 12), $urandom_range(0, 3),
               $urandom_range(0, 3), y, c, mh, mc, mstep, ns);
    mh = y; mc = c; my = y; mstep = ns;
  endtask

  initial begin
    vecs[0] = '{16'h0100, 1'b1, 1'b1, 5, 0, 0, 16'h0040, 16'h0080, 16'h0000, 16'h0000, 3'd0, 3'd0};
    vecs[1] = '{16'h1111, 1'b1, 1'b0, 3, 0, 0, 16'h1a1a, 16'h2b2b, 16'h0000, 16'h0000, 3'd0, 3'd1};
    vecs[2] = '{16'h2222, 1'b0, 1'b0, 2, 0, 0, 16'h3c3c, 16'h4d4d, 16'h1a1a, 16'h2b2b, 3'd1, 3'd2};
    vecs[3] = '{16'h3333, 1'b0, 1'b1, 4, 7, 4, 16'h5e5e, 16'h6f6f, 16'h3c3c, 16'h4d4d, 3'd2, 3'd0};
    vecs[4] = '{16'h4444, 1'b1, 1'b0, 1, 0, 0, 16'h7070, 16'h0101, 16'h0000, 16'h0000, 3'd0, 3'd1};
    vecs[5] = '{16'h5555, 1'b0, 1'b1, 6, 1, 2, 16'hffff, 16'h8000, 16'h7070, 16'h0101, 3'd1, 3'd0};
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst = 0;
    @(negedge clk);
    chk("s_ready_after_rst", s_ready, 1);
    for (int i = 0; i < 6; i++) begin
      run_sample(vecs[i].x, vecs[i].f, vecs[i].l, vecs[i].lat, vecs[i].xs, vecs[i].ms,
                 vecs[i].y, vecs[i].c, vecs[i].eh, vecs[i].ec, vecs[i].s0, vecs[i].s1);
      mh = vecs[i].y; mc = vecs[i].c; my = vecs[i].y; mstep = vecs[i].s1;
    end
    for (int i = 0; i < 40; i++)
      model_sample(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
    for (int i = 0; i < 10; i++) model_sample(i == 0, 1'b0);
    chk("step_saturated", step, 7);
    model_sample(1'b0, 1'b1);
    // stray y_valid while idle must leave every output untouched
    y_out = 16'($urandom); C_out = 16'($urandom); y_valid = 1;
    @(negedge clk);
    y_valid = 0;
    chk("idle_spur_h", h_in, mh);
    chk("idle_spur_C", C_in, mc);
    chk("idle_spur_m_y", m_y, my);
    chk("idle_spur_m_valid", m_valid, 0);
    chk("idle_spur_s_ready", s_ready, 1);
    chk("idle_spur_step", step, mstep);
    model_sample(1'b0, 1'b0);
    accept(16'h0abc, 1'b0, 1'b0);
    x_ready = 1;
    @(negedge clk);
    x_ready = 0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      chk("to_no_m_valid", m_valid, 0);
      if (k == 15) chk("to_err_early", err_timeout, 0);
    end
    @(negedge clk);
    chk("to_err", err_timeout, 1);
    chk("to_s_ready", s_ready, 1);
    chk("to_h_in", h_in, 0);
    chk("to_C_in", C_in, 0);
    chk("to_step", step, 0);
    chk("to_m_valid", m_valid, 0);
    mh = 0; mc = 0; mstep = 0;
    model_sample(1'b0, 1'b1);
    chk("to_err_sticky", err_timeout, 1);
    accept(16'h0def, 1'b1, 1'b0);
    x_ready = 1;
    @(negedge clk);
    x_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_reset_vals();
    y_out = 16'h1234; C_out = 16'h5678; y_valid = 1;
    @(negedge clk);
    y_valid = 0;
    chk("late_y_s_ready", s_ready, 1);
    chk("late_y_m_valid", m_valid, 0);
    chk("late_y_h_in", h_in, 0);
    chk("late_y_m_y", m_y, 0);
    @(negedge clk);
    chk("late_y_m_valid2", m_valid, 0);
    mh = 0; mc = 0; mstep = 0;
    model_sample(1'b0, 1'b0);
    model_sample(1'b0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
